// File: rtl/mips_defs.sv
// Shared MIPS decode constants: opcodes, functs, mult/div op codes and Tuse/Tnew values.
// Also the per-instruction decode record produced by instr_classify.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

    localparam logic [1:0] TNEW_E_JAL  = 2'd0;
    localparam logic [1:0] TNEW_E_ALU  = 2'd1;
    localparam logic [1:0] TNEW_E_LW   = 2'd2;

    // dest == 0 means "writes nothing"; use_* clear means the field is not a source.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       use_rs;
        logic       use_rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [1:0] tnew_e;
        logic       is_md;
        logic       is_md_start;
        md_op_e     md_op;
    } ir_info_t;

endpackage

// File: rtl/instr_classify.sv
// Decodes one instruction word into sources, destination and hazard timing.
// Unknown encodings (including the all-zero nop) decode to no sources and no destination.
module instr_classify
    import mips_defs::*;
(
    input  logic [31:0] ir_i,
    output ir_info_t    info_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = ir_i[31:26];
    assign fn           = ir_i[5:0];
    assign rd           = ir_i[15:11];
    assign unused_shamt = ^ir_i[10:6];

    always_comb begin
        info_o    = '0;
        info_o.rs = ir_i[25:21];
        info_o.rt = ir_i[20:16];
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        info_o.dest    = rd;
                        info_o.use_rs  = 1'b1;
                        info_o.use_rt  = 1'b1;
                        info_o.tuse_rs = TUSE_ALU;
                        info_o.tuse_rt = TUSE_ALU;
                        info_o.tnew_e  = TNEW_E_ALU;
                    end
                    FN_JR: begin
                        info_o.use_rs  = 1'b1;
                        info_o.tuse_rs = TUSE_BRANCH;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        info_o.use_rs      = 1'b1;
                        info_o.use_rt      = 1'b1;
                        info_o.tuse_rs     = TUSE_ALU;
                        info_o.tuse_rt     = TUSE_ALU;
                        info_o.is_md       = 1'b1;
                        info_o.is_md_start = 1'b1;
                        info_o.md_op       = (fn == FN_MULT)  ? MD_MULT  :
                                             (fn == FN_MULTU) ? MD_MULTU :
                                             (fn == FN_DIV)   ? MD_DIV   : MD_DIVU;
                    end
                    FN_MFHI, FN_MFLO: begin
                        info_o.dest   = rd;
                        info_o.tnew_e = TNEW_E_ALU;
                        info_o.is_md  = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        info_o.use_rs  = 1'b1;
                        info_o.tuse_rs = TUSE_ALU;
                        info_o.is_md   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                info_o.dest    = info_o.rt;
                info_o.use_rs  = 1'b1;
                info_o.tuse_rs = TUSE_ALU;
                info_o.tnew_e  = TNEW_E_ALU;
            end
            OP_LUI: begin
                info_o.dest   = info_o.rt;
                info_o.tnew_e = TNEW_E_ALU;
            end
            OP_LW: begin
                info_o.dest    = info_o.rt;
                info_o.use_rs  = 1'b1;
                info_o.tuse_rs = TUSE_ALU;
                info_o.tnew_e  = TNEW_E_LW;
            end
            OP_SW: begin
                info_o.use_rs  = 1'b1;
                info_o.use_rt  = 1'b1;
                info_o.tuse_rs = TUSE_ALU;
                info_o.tuse_rt = TUSE_STORE;
            end
            OP_BEQ: begin
                info_o.use_rs  = 1'b1;
                info_o.use_rt  = 1'b1;
                info_o.tuse_rs = TUSE_BRANCH;
                info_o.tuse_rt = TUSE_BRANCH;
            end
            OP_JAL: begin
                info_o.dest   = 5'd31;
                info_o.tnew_e = TNEW_E_JAL;
            end
            OP_J: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_md_ctrl.sv
// Pipeline stall/bubble controller with Tuse/Tnew hazard detection,
// plus start strobe and busy-window counter for the E-stage mult/div unit.
module hazard_md_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        stall,
    output logic        DE_clr,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_busy
);

    ir_info_t         info_d, info_e, info_m;
    logic [1:0]       tnew_m;
    logic             stall_rs, stall_rt, stall_data, stall_md;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_info;

    instr_classify u_cls_d (.ir_i(IR_D), .info_o(info_d));
    instr_classify u_cls_e (.ir_i(IR_E), .info_o(info_e));
    instr_classify u_cls_m (.ir_i(IR_M), .info_o(info_m));

    assign unused_info = ^{info_d, info_e, info_m};

    // One pipeline stage later every producer is one cycle closer to its result.
    assign tnew_m = (info_m.tnew_e != 2'd0) ? info_m.tnew_e - 2'd1 : 2'd0;

    assign stall_rs = info_d.use_rs && (info_d.rs != 5'd0) &&
                      (((info_d.rs == info_e.dest) && (info_d.tuse_rs < info_e.tnew_e)) ||
                       ((info_d.rs == info_m.dest) && (info_d.tuse_rs < tnew_m)));
    assign stall_rt = info_d.use_rt && (info_d.rt != 5'd0) &&
                      (((info_d.rt == info_e.dest) && (info_d.tuse_rt < info_e.tnew_e)) ||
                       ((info_d.rt == info_m.dest) && (info_d.tuse_rt < tnew_m)));

    assign stall_data = stall_rs | stall_rt;
    assign md_start   = ~reset & info_e.is_md_start;
    assign md_op      = info_e.md_op;
    assign md_busy    = (cnt_q != '0);
    assign stall_md   = info_d.is_md & (md_start | md_busy);
    assign stall      = stall_data | stall_md;
    assign DE_clr     = stall;

    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = ((info_e.md_op == MD_MULT) || (info_e.md_op == MD_MULTU)) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A start during the busy window means the MD stall was bypassed upstream.
    always_ff @(posedge clk) begin
        if (!reset && md_start && md_busy) begin
            $error("hazard_md_ctrl: md_start while mult/div busy, counter reloaded");
        end
    end
`endif

endmodule
